// File: rtl/gpu_cmd_pkg.sv
// Shared command-decoder definitions: opcodes, CMD/BUSY bit positions,
// vertex-loader state encoding and error-flag bit positions.
package gpu_cmd_pkg;

  localparam logic [3:0] OP_SWAP              = 4'h0;
  localparam logic [3:0] OP_CLEAR             = 4'h1;
  localparam logic [3:0] OP_LOAD_VERTEX_BEGIN = 4'h2;
  localparam logic [3:0] OP_LOAD_VERTEX_CONT  = 4'h3;
  localparam logic [3:0] OP_LOAD_EDGE_BEGIN   = 4'h4;
  localparam logic [3:0] OP_LOAD_EDGE_CONT    = 4'h5;
  localparam logic [3:0] OP_DRAW              = 4'h6;
  localparam logic [3:0] OP_STATUS            = 4'h7;

  // Bit positions within the one-hot CMD strobe and BUSY vectors
  localparam int SWAP_IDX              = 0;
  localparam int CLEAR_IDX             = 1;
  localparam int LOAD_VERTEX_BEGIN_IDX = 2;
  localparam int LOAD_VERTEX_CONT_IDX  = 3;
  localparam int LOAD_EDGE_BEGIN_IDX   = 4;
  localparam int LOAD_EDGE_CONT_IDX    = 5;
  localparam int DRAW_IDX              = 6;
  localparam int STATUS_IDX            = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } load_state_t;

  localparam int ERR_BAD_COUNT = 0;
  localparam int ERR_TIMEOUT   = 1;
  localparam int ERR_OVERFLOW  = 2;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter: load restarts the gap window, enable counts it down,
// expire is high once the window has fully elapsed.
module gap_timer
  import gpu_cmd_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (rst)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (enable && (cnt_q != '0))
      cnt_q <= cnt_q - 1'b1;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/vertex_load_ctrl.sv
// Vertex-buffer load sequencer: gathers X/Y/Z from CONT pulses, writes each
// vertex to vertex RAM over a valid/ready port, with a one-entry skid for CONTs.
module vertex_load_ctrl
  import gpu_cmd_pkg::*;
#(
  parameter int COORD_W     = 16,
  parameter int ADDR_W      = 10,
  parameter int MAX_VERTS   = 1024,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 cmd_begin,
  input  logic                 cmd_cont,
  input  logic [31:0]          payload,
  output logic                 busy,
  output logic                 vram_we,
  input  logic                 vram_ready,
  output logic [ADDR_W-1:0]    vram_addr,
  output logic [3*COORD_W-1:0] vram_wdata,
  output logic                 done,
  output logic [2:0]           err
);

  localparam int TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  load_state_t state_q, state_d;
  logic [ADDR_W:0]      count_q, count_d, index_q, index_d, index_inc;
  logic [1:0]           sel_q, sel_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d, skid_q, skid_d, coord;
  logic                 skid_full_q, skid_full_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [3*COORD_W-1:0] wdata_d;
  logic                 done_d;
  logic [2:0]           err_d;
  logic                 tmr_load, tmr_en, tmr_expire, timeout_hit, accept;
  logic                 unused_payload;

  assign coord          = payload[COORD_W-1:0];
  assign unused_payload = ^payload[31:COORD_W];
  assign index_inc      = index_q + 1'b1;
  assign accept         = (state_q == WRITE) && vram_ready;
  assign timeout_hit    = (TIMEOUT_CYC != 0) && tmr_expire;
  assign busy           = (state_q != IDLE);
  assign vram_we        = (state_q == WRITE);

  gap_timer #(.W(TMR_W)) u_gap_timer (
    .CLK      (CLK),
    .rst      (rst),
    .load     (tmr_load),
    .enable   (tmr_en),
    .load_val (TMR_W'(TIMEOUT_CYC)),
    .expire   (tmr_expire)
  );

  always_ff @(posedge CLK) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    sel_d       = sel_q;
    x_d         = x_q;
    y_d         = y_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    addr_d      = vram_addr;
    wdata_d     = vram_wdata;
    done_d      = 1'b0;
    err_d       = err;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_begin) begin
          if (payload[15:0] == 16'd0) begin
            done_d = 1'b1;
          end else if (payload[15:0] > 16'(MAX_VERTS)) begin
            err_d[ERR_BAD_COUNT] = 1'b1;
          end else begin
            count_d     = payload[ADDR_W:0];
            index_d     = '0;
            sel_d       = 2'd0;
            skid_full_d = 1'b0;
            err_d       = 3'b000;
            tmr_load    = 1'b1;
            state_d     = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (cmd_cont) begin
          tmr_load = 1'b1;
          unique case (sel_q)
            2'd0: begin x_d = coord; sel_d = 2'd1; end
            2'd1: begin y_d = coord; sel_d = 2'd2; end
            default: begin
              addr_d  = index_q[ADDR_W-1:0];
              wdata_d = {coord, y_q, x_q};
              sel_d   = 2'd0;
              state_d = WRITE;
            end
          endcase
        end else begin
          tmr_en = 1'b1;
          if (timeout_hit) begin
            sel_d   = 2'd0;
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WRITE: begin
        // CONTs here (including the accept cycle) go through the skid entry
        if (cmd_cont) begin
          if (skid_full_q) begin
            err_d[ERR_OVERFLOW] = 1'b1;
          end else begin
            skid_d      = coord;
            skid_full_d = 1'b1;
          end
        end
        if (accept) begin
          index_d = index_inc;
          sel_d   = 2'd0;
          if (index_inc == count_q) begin
            skid_full_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            tmr_load = 1'b1;
            state_d  = COLLECT;
            if (skid_full_q || cmd_cont) begin
              x_d         = skid_full_q ? skid_q : coord;
              sel_d       = 2'd1;
              skid_full_d = 1'b0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      count_q     <= '0;
      index_q     <= '0;
      sel_q       <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      vram_addr   <= '0;
      vram_wdata  <= '0;
      done        <= 1'b0;
      err         <= 3'b000;
    end else begin
      count_q     <= count_d;
      index_q     <= index_d;
      sel_q       <= sel_d;
      x_q         <= x_d;
      y_q         <= y_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      vram_addr   <= addr_d;
      vram_wdata  <= wdata_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_vertex_load_ctrl.sv
// Directed self-checking bench for vertex_load_ctrl (timeout shortened to 8).
module tb_vertex_load_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic        cmd_begin;
  logic        cmd_cont;
  logic [31:0] payload;
  logic        busy;
  logic        vram_we;
  logic        vram_ready;
  logic [9:0]  vram_addr;
  logic [47:0] vram_wdata;
  logic        done;
  logic [2:0]  err;

  int passed = 0;
  int total  = 0;

  vertex_load_ctrl #(
    .COORD_W(16), .ADDR_W(10), .MAX_VERTS(1024), .TIMEOUT_CYC(8)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .cmd_begin  (cmd_begin),
    .cmd_cont   (cmd_cont),
    .payload    (payload),
    .busy       (busy),
    .vram_we    (vram_we),
    .vram_ready (vram_ready),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .done       (done),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_begin(input int cnt);
    cmd_begin = 1'b1;
    payload   = 32'(cnt);
    tick();
    cmd_begin = 1'b0;
    payload   = '0;
  endtask

  task automatic send_cont(input int val);
    cmd_cont = 1'b1;
    payload  = 32'(val);
    tick();
    cmd_cont = 1'b0;
    payload  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_begin = 1'b0; cmd_cont = 1'b0; payload = '0; vram_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (vram_we !== 1'b0) $display("[TB] FAIL reset_we: got %b expected 0", vram_we); else passed++;
    total++; if (vram_addr !== 10'd0) $display("[TB] FAIL reset_addr: got %h expected 0", vram_addr); else passed++;
    total++; if (vram_wdata !== 48'd0) $display("[TB] FAIL reset_wdata: got %h expected 0", vram_wdata); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (err !== 3'b000) $display("[TB] FAIL reset_err: got %b expected 000", err); else passed++;
  endtask

  task automatic test_basic_load();
    vram_ready = 1'b1;
    send_begin(2);
    total++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy_begin: got %b expected 1", busy); else passed++;
    send_cont(1); tick(); send_cont(2); tick(); send_cont(3);
    total++; if (vram_we !== 1'b1) $display("[TB] FAIL basic_we0: got %b expected 1", vram_we); else passed++;
    total++; if (vram_addr !== 10'd0) $display("[TB] FAIL basic_addr0: got %h expected 0", vram_addr); else passed++;
    total++; if (vram_wdata !== {16'd3, 16'd2, 16'd1}) $display("[TB] FAIL basic_wdata0: got %h expected %h", vram_wdata, {16'd3, 16'd2, 16'd1}); else passed++;
    tick();
    total++; if (vram_we !== 1'b0) $display("[TB] FAIL basic_we_drop: got %b expected 0", vram_we); else passed++;
    total++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy_mid: got %b expected 1", busy); else passed++;
    send_cont(4); tick(); send_cont(5); tick(); send_cont(6);
    total++; if (vram_we !== 1'b1) $display("[TB] FAIL basic_we1: got %b expected 1", vram_we); else passed++;
    total++; if (vram_addr !== 10'd1) $display("[TB] FAIL basic_addr1: got %h expected 1", vram_addr); else passed++;
    total++; if (vram_wdata !== {16'd6, 16'd5, 16'd4}) $display("[TB] FAIL basic_wdata1: got %h expected %h", vram_wdata, {16'd6, 16'd5, 16'd4}); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL basic_done_early: got %b expected 0", done); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("[TB] FAIL basic_done: got %b expected 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_end: got %b expected 0", busy); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); else passed++;
  endtask

  task automatic test_stall_skid();
    vram_ready = 1'b0;
    send_begin(3);
    send_cont(10); send_cont(11); send_cont(12);
    for (int i = 0; i < 5; i++) begin
      total++; if (vram_we !== 1'b1) $display("[TB] FAIL stall_we_%0d: got %b expected 1", i, vram_we); else passed++;
      total++; if (vram_addr !== 10'd0) $display("[TB] FAIL stall_addr_%0d: got %h expected 0", i, vram_addr); else passed++;
      total++; if (vram_wdata !== {16'd12, 16'd11, 16'd10}) $display("[TB] FAIL stall_wdata_%0d: got %h expected %h", i, vram_wdata, {16'd12, 16'd11, 16'd10}); else passed++;
      if (i == 1) send_cont(13); else tick();
    end
    vram_ready = 1'b1;
    tick();
    total++; if (vram_we !== 1'b0) $display("[TB] FAIL stall_accept: got %b expected 0", vram_we); else passed++;
    send_cont(14); send_cont(15);
    total++; if (vram_addr !== 10'd1) $display("[TB] FAIL skid_addr1: got %h expected 1", vram_addr); else passed++;
    total++; if (vram_wdata !== {16'd15, 16'd14, 16'd13}) $display("[TB] FAIL skid_wdata1: got %h expected %h", vram_wdata, {16'd15, 16'd14, 16'd13}); else passed++;
    tick();
    send_cont(16); send_cont(17); send_cont(18);
    total++; if (vram_wdata !== {16'd18, 16'd17, 16'd16}) $display("[TB] FAIL skid_wdata2: got %h expected %h", vram_wdata, {16'd18, 16'd17, 16'd16}); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("[TB] FAIL skid_done: got %b expected 1", done); else passed++;
    total++; if (err !== 3'b000) $display("[TB] FAIL skid_err: got %b expected 000", err); else passed++;
    tick();
  endtask

  task automatic test_overflow();
    vram_ready = 1'b0;
    send_begin(2);
    send_cont(20); send_cont(21); send_cont(22);
    send_cont(23); send_cont(24);
    total++; if (err !== 3'b100) $display("[TB] FAIL ovf_err: got %b expected 100", err); else passed++;
    total++; if (vram_wdata !== {16'd22, 16'd21, 16'd20}) $display("[TB] FAIL ovf_wdata0: got %h expected %h", vram_wdata, {16'd22, 16'd21, 16'd20}); else passed++;
    vram_ready = 1'b1;
    tick();
    send_cont(25); send_cont(26);
    total++; if (vram_addr !== 10'd1) $display("[TB] FAIL ovf_addr1: got %h expected 1", vram_addr); else passed++;
    total++; if (vram_wdata !== {16'd26, 16'd25, 16'd23}) $display("[TB] FAIL ovf_wdata1: got %h expected %h", vram_wdata, {16'd26, 16'd25, 16'd23}); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("[TB] FAIL ovf_done: got %b expected 1", done); else passed++;
    total++; if (err !== 3'b100) $display("[TB] FAIL ovf_err_sticky: got %b expected 100", err); else passed++;
    tick();
  endtask

  task automatic test_timeout();
    logic saw_we;
    logic saw_done;
    saw_we = 1'b0; saw_done = 1'b0;
    vram_ready = 1'b1;
    send_begin(1);
    send_cont(30); send_cont(31);
    for (int i = 1; i <= 9; i++) begin
      tick();
      saw_we   = saw_we | vram_we;
      saw_done = saw_done | done;
      if (i == 7) begin
        total++; if (busy !== 1'b1) $display("[TB] FAIL to_busy_before: got %b expected 1", busy); else passed++;
      end
    end
    total++; if (busy !== 1'b0) $display("[TB] FAIL to_busy_after: got %b expected 0", busy); else passed++;
    total++; if (err !== 3'b010) $display("[TB] FAIL to_err: got %b expected 010", err); else passed++;
    total++; if (saw_we !== 1'b0) $display("[TB] FAIL to_no_we: got %b expected 0", saw_we); else passed++;
    total++; if (saw_done !== 1'b0) $display("[TB] FAIL to_no_done: got %b expected 0", saw_done); else passed++;
    send_begin(1);
    total++; if (err !== 3'b000) $display("[TB] FAIL to_err_clear: got %b expected 000", err); else passed++;
    send_cont(40); send_cont(41); send_cont(42);
    total++; if (vram_wdata !== {16'd42, 16'd41, 16'd40}) $display("[TB] FAIL to_reload_wdata: got %h expected %h", vram_wdata, {16'd42, 16'd41, 16'd40}); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("[TB] FAIL to_reload_done: got %b expected 1", done); else passed++;
    tick();
  endtask

  task automatic test_count_bounds();
    send_begin(0);
    total++; if (done !== 1'b1) $display("[TB] FAIL zero_done: got %b expected 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy: got %b expected 0", busy); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("[TB] FAIL zero_done_pulse: got %b expected 0", done); else passed++;
    send_begin(2000);
    total++; if (err !== 3'b001) $display("[TB] FAIL bad_err: got %b expected 001", err); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL bad_busy: got %b expected 0", busy); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("[TB] FAIL bad_busy_hold: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_begin_priority();
    vram_ready = 1'b1;
    cmd_begin = 1'b1; cmd_cont = 1'b1; payload = 32'd1;
    tick();
    cmd_begin = 1'b0; cmd_cont = 1'b0; payload = '0;
    total++; if (busy !== 1'b1) $display("[TB] FAIL prio_busy: got %b expected 1", busy); else passed++;
    send_cont(70);
    send_begin(3);
    send_cont(71); send_cont(72);
    total++; if (vram_we !== 1'b1) $display("[TB] FAIL prio_we: got %b expected 1", vram_we); else passed++;
    total++; if (vram_wdata !== {16'd72, 16'd71, 16'd70}) $display("[TB] FAIL prio_wdata: got %h expected %h", vram_wdata, {16'd72, 16'd71, 16'd70}); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("[TB] FAIL prio_done: got %b expected 1", done); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_load();
    vram_ready = 1'b1;
    send_begin(1);
    send_cont(50); send_cont(51);
    rst = 1'b1;
    tick();
    total++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
    total++; if (vram_we !== 1'b0) $display("[TB] FAIL rst_mid_we: got %b expected 0", vram_we); else passed++;
    total++; if (vram_wdata !== 48'd0) $display("[TB] FAIL rst_mid_wdata: got %h expected 0", vram_wdata); else passed++;
    total++; if (err !== 3'b000) $display("[TB] FAIL rst_mid_err: got %b expected 000", err); else passed++;
    rst = 1'b0;
    tick();
    send_begin(1);
    send_cont(60);
    total++; if (vram_we !== 1'b0) $display("[TB] FAIL rst_new_we_early: got %b expected 0", vram_we); else passed++;
    send_cont(61); send_cont(62);
    total++; if (vram_addr !== 10'd0) $display("[TB] FAIL rst_new_addr: got %h expected 0", vram_addr); else passed++;
    total++; if (vram_wdata !== {16'd62, 16'd61, 16'd60}) $display("[TB] FAIL rst_new_wdata: got %h expected %h", vram_wdata, {16'd62, 16'd61, 16'd60}); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("[TB] FAIL rst_new_done: got %b expected 1", done); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stall_skid();
    test_overflow();
    test_timeout();
    test_count_bounds();
    test_begin_priority();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
